// File: rtl/cpu_trace_buffer.sv
// Commit-trace capture: records retired instructions with a cycle timestamp into a
// circular buffer, with optional PC trigger and post-trigger stop. Drained over valid/ready.
//
//   state | meaning
//   ARMED | idle or waiting for trig_pc match; nothing captured except the trigger commit
//   CAPT  | every commit is captured
//   DONE  | post-trigger budget spent; no captures, draining continues
module cpu_trace_buffer #(
    parameter int PCW      = 32,
    parameter int DW       = 32,
    parameter int DEPTH    = 16,
    parameter int TSW      = 16,
    parameter int POST_CNT = 0,
    localparam int EW = TSW + PCW + 32 + 1 + 5 + DW,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           enable,
    input  logic           clear,
    input  logic           mode_wrap,
    input  logic           trig_en,
    input  logic [PCW-1:0] trig_pc,
    input  logic           cmt_valid,
    input  logic [PCW-1:0] cmt_pc,
    input  logic [31:0]    cmt_instr,
    input  logic           cmt_wen,
    input  logic [4:0]     cmt_waddr,
    input  logic [DW-1:0]  cmt_wdata,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [EW-1:0]  out_data,
    output logic [CW-1:0]  count,
    output logic           triggered,
    output logic           overflow,
    output logic [15:0]    dropped_cnt
);
    localparam int PW = (POST_CNT > 1) ? $clog2(POST_CNT + 1) : 1;
    localparam logic [PW-1:0] POST_INIT = PW'(POST_CNT);

    typedef enum logic [1:0] {ARMED, CAPT, DONE} state_t;

    state_t          state, state_nxt;
    logic [TSW-1:0]  ts;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [PW-1:0]   post_left;
    logic            capture, trig_hit, post_tc;
    logic            full, pop, wr_en, drop, overwrite;

    // post_left counts down captures still allowed; terminal count is the last one
    assign post_tc   = (POST_CNT != 0) && (post_left == PW'(1));
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        trig_hit  = 1'b0;
        case (state)
            ARMED: begin
                if (enable && !trig_en) begin
                    state_nxt = CAPT;
                end else if (enable && cmt_valid && (cmt_pc == trig_pc)) begin
                    capture   = 1'b1;
                    trig_hit  = 1'b1;
                    state_nxt = post_tc ? DONE : CAPT;
                end
            end
            CAPT: begin
                if (cmt_valid) begin
                    capture = 1'b1;
                    if (post_tc) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = ARMED;
        endcase
        if (!enable) begin
            state_nxt = ARMED;
            capture   = 1'b0;
            trig_hit  = 1'b0;
        end
    end

    always_comb begin
        full      = (count == CW'(DEPTH));
        pop       = out_valid && out_ready;
        wr_en     = capture && (!full || pop || mode_wrap);
        drop      = capture && full && !pop;
        overwrite = drop && mode_wrap;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ARMED;
            ts          <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            triggered   <= 1'b0;
            overflow    <= 1'b0;
            dropped_cnt <= '0;
            post_left   <= POST_INIT;
        end else begin
            ts <= ts + 1'b1;
            if (clear) begin
                state       <= ARMED;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                count       <= '0;
                triggered   <= 1'b0;
                overflow    <= 1'b0;
                dropped_cnt <= '0;
                post_left   <= POST_INIT;
            end else begin
                state <= state_nxt;
                if (state_nxt == ARMED) begin
                    post_left <= POST_INIT;
                    triggered <= 1'b0;
                end else begin
                    if (capture)  post_left <= post_left - 1'b1;
                    if (trig_hit) triggered <= 1'b1;
                end
                if (wr_en) wr_ptr <= wr_ptr + 1'b1;
                // an overwrite retires the oldest entry, so the read side moves too
                if (pop || overwrite) rd_ptr <= rd_ptr + 1'b1;
                if (wr_en && !pop && !overwrite) count <= count + 1'b1;
                else if (pop && !wr_en)          count <= count - 1'b1;
                if (drop) begin
                    overflow <= 1'b1;
                    if (dropped_cnt != 16'hFFFF) dropped_cnt <= dropped_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && !clear && wr_en)
            mem[wr_ptr] <= {ts, cmt_pc, cmt_instr, cmt_wen, cmt_waddr, cmt_wdata};
    end

endmodule
